// File: rtl/pipe_hazard_if.sv
// Data-memory handshake between the hazard controller and the MEM stage / memory.
// dm_valid is held by the controller until the memory raises dm_ack in the same cycle.
interface pipe_hazard_if;
  logic dm_req_mem;
  logic dm_ack;
  logic dm_valid;

  modport master (
    input  dm_req_mem,
    input  dm_ack,
    output dm_valid
  );

  modport slave (
    output dm_req_mem,
    output dm_ack,
    input  dm_valid
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for a 5-stage RV32I core: load-use bubbles,
// taken-branch squash and data-memory freeze with a sticky timeout fault.
module pipe_hazard_ctrl #(
  parameter int DM_TIMEOUT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             load_ex,
  input  logic             branch_taken_ex,
  pipe_hazard_if.master    dm_if,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       o_state
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  localparam int WC_W      = (DM_TIMEOUT < 1) ? 1 : $clog2(DM_TIMEOUT + 1);
  localparam int WC_LAST_I = (DM_TIMEOUT > 0) ? DM_TIMEOUT - 1 : 0;
  localparam logic [WC_W-1:0] WC_LAST = WC_LAST_I[WC_W-1:0];

  logic [1:0]       r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_fault;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0]       w_state_nxt;
  logic [WC_W-1:0]  w_wait_nxt;
  logic             w_load_use;
  logic             w_dm_valid;

  // Outputs of an advancing cycle (RUN without a pending access, or the ack cycle).
  logic w_adv_pc_en;
  logic w_adv_if_id_en;
  logic w_adv_if_id_flush;
  logic w_adv_id_ex_flush;

  assign w_load_use = load_ex && (rd_ex != 5'd0) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));

  always_comb begin
    w_adv_pc_en       = 1'b1;
    w_adv_if_id_en    = 1'b1;
    w_adv_if_id_flush = 1'b0;
    w_adv_id_ex_flush = 1'b0;
    if (branch_taken_ex) begin
      w_adv_if_id_flush = 1'b1;
      w_adv_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      w_adv_pc_en       = 1'b0;
      w_adv_if_id_en    = 1'b0;
      w_adv_id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    w_dm_valid   = 1'b0;
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;

    case (r_state)
      ST_RUN: begin
        w_dm_valid = dm_if.dm_req_mem;
        if (dm_if.dm_req_mem && !dm_if.dm_ack) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
          w_wait_nxt   = WC_W'(1);
          w_state_nxt  = (DM_TIMEOUT == 1) ? ST_FAULT : ST_MEM_WAIT;
        end else begin
          pc_en       = w_adv_pc_en;
          if_id_en    = w_adv_if_id_en;
          if_id_flush = w_adv_if_id_flush;
          id_ex_flush = w_adv_id_ex_flush;
        end
      end

      ST_MEM_WAIT: begin
        w_dm_valid = 1'b1;
        if (dm_if.dm_ack) begin
          pc_en       = w_adv_pc_en;
          if_id_en    = w_adv_if_id_en;
          if_id_flush = w_adv_if_id_flush;
          id_ex_flush = w_adv_id_ex_flush;
          w_wait_nxt  = '0;
          w_state_nxt = ST_RUN;
        end else begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
          if ((DM_TIMEOUT != 0) && (r_wait_cnt == WC_LAST)) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_wait_nxt = r_wait_cnt + WC_W'(1);
          end
        end
      end

      default: begin
        // FAULT and any unused encoding: everything frozen until reset.
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        w_state_nxt = ST_FAULT;
      end
    endcase

    // Reset fills every stage with bubbles regardless of state.
    if (!rst_n) begin
      pc_en        = 1'b0;
      w_dm_valid   = 1'b0;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_fault     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_fault    <= r_fault | (w_state_nxt == ST_FAULT);
      if ((r_state != ST_FAULT) && !pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign dm_if.dm_valid = w_dm_valid;
  assign fault          = r_fault;
  assign stall_cnt      = r_stall_cnt;
  assign o_state        = r_state;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the RV32I 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage enable/flush to:
  - insert load-use bubbles;
  - squash wrong-path instructions on taken branches/jumps;
  - freeze the pipeline while data memory is busy (valid/ack handshake with timeout fault).
- Sits beside the datapath; all pipeline registers take their en/flush from this block.

Parameters:
DM_TIMEOUT, 16, consecutive un-acked dm request cycles before FAULT; 0 disables timeout
CNT_W, 16, width of stall performance counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
rs1_id  input  5  rs1 of instruction in ID
rs2_id  input  5  rs2 of instruction in ID
rd_ex  input  5  rd of instruction in EX
load_ex  input  1  instruction in EX is a load
branch_taken_ex  input  1  taken branch/jump resolved in EX
dm_req_mem  input  1  instruction in MEM accesses data memory
dm_ack  input  1  data memory completes access this cycle
dm_valid  output  1  request strobe to data memory
pc_en  output  1  PC update enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  stage register load enable
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  load bubble (all-zero control) instead of data; effective only when matching en=1
fault  output  1  sticky dm timeout flag
stall_cnt  output  CNT_W  saturating count of cycles with pc_en=0 (excluding reset/FAULT)

Behaviour:
- Reset: synchronous, applied while rst_n=0.
  - Registered state: state<=RUN, wait_cnt<=0, fault<=0, stall_cnt<=0.
  - Outputs while rst_n=0 (combinational override): pc_en=0, dm_valid=0, all *_en=1, all *_flush=1 (pipeline filled with bubbles).
  - Reset mid-MEM_WAIT or in FAULT: abandons the access and returns to RUN next cycle.
- States: RUN, MEM_WAIT, FAULT. Outputs are combinational from state and inputs; zero-latency decisions.
- Load-use hazard: load_use = load_ex && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id).
- RUN, priority high to low:
  1. dm_req_mem && !dm_ack:
     - dm_valid=1; pc_en, if_id_en, id_ex_en, ex_mem_en=0;
     - mem_wb_en=1 with mem_wb_flush=1 (bubble to WB);
     - wait_cnt<=1; next MEM_WAIT (FAULT directly if DM_TIMEOUT==1).
  2. branch_taken_ex: all en=1; if_id_flush=1, id_ex_flush=1; overrides load_use.
  3. load_use: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1; ex_mem_en, mem_wb_en=1.
  4. Otherwise: all en=1, all flush=0.
  - dm_valid=dm_req_mem in all RUN cases; zero-wait ack (dm_ack=1 in same cycle) causes no stall.
- MEM_WAIT:
  - dm_valid=1; freeze as in RUN case 1; branch/load_use ignored (EX frozen).
  - dm_ack=1: that cycle behaves as RUN cases 2-4 (MEM advances); next RUN; wait_cnt<=0.
  - No ack and DM_TIMEOUT!=0 and wait_cnt==DM_TIMEOUT-1: next FAULT. Otherwise wait_cnt<=wait_cnt+1.
  - Width of wait_cnt: $clog2(DM_TIMEOUT+1), minimum 1.
- FAULT:
  - pc_en and all en=0; flushes=0; dm_valid=0; fault=1 (registered, set on entry).
  - Exits only via reset; dm_ack ignored.
- stall_cnt: increments by 1 each non-reset cycle where state!=FAULT and pc_en=0; saturates at all-ones.
- Simultaneous branch_taken_ex and load_use: branch wins, no stall counted.
- rd_ex==0 never causes a stall.

Test Plan:
- Reset: rst_n=0 for 2 cycles with dm_req_mem=1 -> all en=1, all flush=1, pc_en=0, dm_valid=0; after release fault=0, stall_cnt=0.
- Load-use: load_ex=1, rd_ex=5, rs2_id=5 -> exactly 1 cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Repeat with rd_ex=0 -> no stall.
- Branch vs load-use: branch_taken_ex=1 with load_use true -> if_id_flush=id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- DM wait: dm_req_mem=1, dm_ack arrives after 3 wait cycles -> 3 cycles frozen with mem_wb_flush=1, dm_valid high throughout; ack cycle all en=1; stall_cnt+=3. Zero-wait ack -> no freeze.
- Timeout: DM_TIMEOUT=4, never ack -> FAULT entered after 4 un-acked cycles; fault=1, all en=0; late dm_ack has no effect; rst_n=0 clears to RUN.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt holds 15.
